// File: rtl/mdu_pkg.sv
// Shared constants and types for the RV32M multiply issue path.
package mdu_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011
    } mul_f3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic signed_a;
        logic signed_b;
        logic upper;
    } mul_ctrl_t;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Core request, multiplier and writeback signals of the multiply issue controller.
interface mul_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [6:0]      opcode_i;
    logic [2:0]      funct3_i;
    logic [6:0]      funct7_i;
    logic [4:0]      rd_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            flush_i;
    logic            mult_en_o;
    logic [XLEN-1:0] op_A_o;
    logic [XLEN-1:0] op_B_o;
    logic            signed_A_o;
    logic            signed_B_o;
    logic            upper_o;
    logic [XLEN-1:0] mult_result_i;
    logic            mult_done_i;
    logic            wb_valid_o;
    logic            wb_ready_i;
    logic [4:0]      wb_rd_o;
    logic [XLEN-1:0] wb_data_o;
    logic            wb_err_o;
    logic            unsupported_o;

    modport slave (
        input  req_valid_i, opcode_i, funct3_i, funct7_i, rd_i, rs1_data_i, rs2_data_i,
               flush_i, mult_result_i, mult_done_i, wb_ready_i,
        output req_ready_o, mult_en_o, op_A_o, op_B_o, signed_A_o, signed_B_o, upper_o,
               wb_valid_o, wb_rd_o, wb_data_o, wb_err_o, unsupported_o
    );

    modport master (
        output req_valid_i, opcode_i, funct3_i, funct7_i, rd_i, rs1_data_i, rs2_data_i,
               flush_i, mult_result_i, mult_done_i, wb_ready_i,
        input  req_ready_o, mult_en_o, op_A_o, op_B_o, signed_A_o, signed_B_o, upper_o,
               wb_valid_o, wb_rd_o, wb_data_o, wb_err_o, unsupported_o
    );

endinterface

// File: rtl/mul_issue_ctrl_decoder.sv
// Combinational RV32M multiply decode: multiply detect plus signedness/upper-half select.
module decoder
    import mdu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       is_mul,
    output mul_ctrl_t  ctrl
);

    always_comb begin
        is_mul = (opcode == OPC_OP) && (funct7 == F7_MULDIV) && !funct3[2];
        ctrl   = '0;
        case (mul_f3_e'(funct3))
            F3_MULH: begin
                ctrl.signed_a = 1'b1;
                ctrl.signed_b = 1'b1;
                ctrl.upper    = 1'b1;
            end
            F3_MULHSU: begin
                ctrl.signed_a = 1'b1;
                ctrl.upper    = 1'b1;
            end
            F3_MULHU: ctrl.upper = 1'b1;
            default:  ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback controller in front of the multiplier: one op in flight, done gating,
// latency watchdog, back-pressured writeback and flush.
module mul_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_LAT  = 4,
    parameter int MAX_WAIT = 16
) (
    input logic             clk_i,
    input logic             rst_i,
    mul_issue_ctrl_if.slave mdu
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t DONE_GATE = cnt_t'(MUL_LAT - 1);
    localparam cnt_t WAIT_LAST = cnt_t'(MAX_WAIT - 1);
    localparam cnt_t CNT_SAT   = '1;

    state_e    state;
    state_e    state_nxt;
    cnt_t      cnt;
    logic      is_mul;
    mul_ctrl_t dec_ctrl;
    logic      req_ready;
    logic      accept;
    logic      done_ok;
    logic      timeout;

    decoder u_decoder (
        .opcode (mdu.opcode_i),
        .funct3 (mdu.funct3_i),
        .funct7 (mdu.funct7_i),
        .is_mul (is_mul),
        .ctrl   (dec_ctrl)
    );

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        done_ok   = 1'b0;
        timeout   = 1'b0;

        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_RESP: req_ready = mdu.wb_ready_i;
            default: req_ready = 1'b0;
        endcase
        if (mdu.flush_i)
            req_ready = 1'b0;
        accept = mdu.req_valid_i && req_ready;

        case (state)
            ST_IDLE: begin
                if (accept && is_mul)
                    state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                // Early done pulses (e.g. left over from a flushed op) are filtered here.
                done_ok = mdu.mult_done_i && (cnt >= DONE_GATE);
                timeout = !done_ok && (cnt == WAIT_LAST);
                if (done_ok || timeout)
                    state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (mdu.wb_ready_i)
                    state_nxt = (accept && is_mul) ? ST_BUSY : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (mdu.flush_i) begin
            state_nxt = ST_IDLE;
            done_ok   = 1'b0;
            timeout   = 1'b0;
        end
    end

    assign mdu.req_ready_o = req_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt               <= '0;
            mdu.mult_en_o     <= 1'b0;
            mdu.op_A_o        <= '0;
            mdu.op_B_o        <= '0;
            mdu.signed_A_o    <= 1'b0;
            mdu.signed_B_o    <= 1'b0;
            mdu.upper_o       <= 1'b0;
            mdu.wb_valid_o    <= 1'b0;
            mdu.wb_rd_o       <= '0;
            mdu.wb_data_o     <= '0;
            mdu.wb_err_o      <= 1'b0;
            mdu.unsupported_o <= 1'b0;
        end else begin
            mdu.mult_en_o     <= (state_nxt == ST_BUSY);
            mdu.wb_valid_o    <= (state_nxt == ST_RESP);
            mdu.unsupported_o <= accept && !is_mul;

            if (accept && is_mul) begin
                cnt            <= '0;
                mdu.op_A_o     <= mdu.rs1_data_i;
                mdu.op_B_o     <= mdu.rs2_data_i;
                mdu.signed_A_o <= dec_ctrl.signed_a;
                mdu.signed_B_o <= dec_ctrl.signed_b;
                mdu.upper_o    <= dec_ctrl.upper;
                mdu.wb_rd_o    <= mdu.rd_i;
            end else if (state == ST_BUSY && cnt != CNT_SAT) begin
                cnt <= cnt + cnt_t'(1);
            end

            if (done_ok) begin
                mdu.wb_data_o <= mdu.mult_result_i;
                mdu.wb_err_o  <= 1'b0;
            end else if (timeout) begin
                mdu.wb_data_o <= '0;
                mdu.wb_err_o  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Issue/writeback controller sitting directly upstream of `multiplier_top`. It accepts one RV32M multiply request at a time from the core, with a valid/ready handshake, and decodes opcode/funct3/funct7. It holds operands and control stable into the multiplier, waits for `done`, and returns the selected 32-bit result to writeback with back-pressure, flush and a latency watchdog.

## Interface
- `XLEN`, 32: operand/result width.
- `MUL_LAT`, 4: minimum multiplier latency in cycles; `mult_done_i` is ignored before this.
- `MAX_WAIT`, 16: watchdog limit in BUSY cycles; must be > `MUL_LAT`.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset; asynchronous and active-high.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when high with `req_valid_i`.
- `opcode_i`  in  7  instruction opcode.
- `funct3_i`  in  3  instruction funct3.
- `funct7_i`  in  7  instruction funct7.
- `rd_i`  in  5  destination register tag.
- `rs1_data_i`  in  XLEN  operand A.
- `rs2_data_i`  in  XLEN  operand B.
- `flush_i`  in  1  abort in-flight op.
- `mult_en_o`  out  1  multiplier enable, level.
- `op_A_o`  out  XLEN  to multiplier.
- `op_B_o`  out  XLEN  to multiplier.
- `signed_A_o`  out  1  to multiplier.
- `signed_B_o`  out  1  to multiplier.
- `upper_o`  out  1  to multiplier.
- `mult_result_i`  in  XLEN  multiplier result.
- `mult_done_i`  in  1  multiplier done.
- `wb_valid_o`  out  1  result valid.
- `wb_ready_i`  in  1  writeback accepts.
- `wb_rd_o`  out  5  result tag.
- `wb_data_o`  out  XLEN  result.
- `wb_err_o`  out  1  watchdog timeout flag, qualified by `wb_valid_o`.
- `unsupported_o`  out  1  one-cycle pulse for a non-multiply request.

## Operation
- A request is a multiply when `opcode_i`=0110011, `funct7_i`=0000001 and `funct3_i[2]`=0.
- Control decode (signed_A, signed_B, upper):
  - MUL 000: 0,0,0.
  - MULH 001: 1,1,1.
  - MULHSU 010: 1,0,1.
  - MULHU 011: 0,0,1.
- FSM states: IDLE, BUSY, RESP.
- IDLE: `req_ready_o`=1.
  - Accepting a multiply latches operands, control and rd, clears `cnt`, and goes to BUSY.
  - Accepting any other request (including DIV/REM) pulses `unsupported_o` next cycle, produces no writeback and stays in IDLE.
- BUSY: `mult_en_o`=1 and `req_ready_o`=0. `cnt` increments per cycle, saturating.
  - `mult_done_i` is honoured only when `cnt` >= `MUL_LAT`-1. Then `mult_result_i` is latched into `wb_data_o`, `wb_err_o`=0, next state RESP.
  - If `cnt`==`MAX_WAIT`-1 without an honoured done: `wb_data_o`=0, `wb_err_o`=1, next state RESP.
- RESP: `wb_valid_o`=1; `wb_data_o`, `wb_rd_o` and `wb_err_o` are stable until `wb_ready_i`.
  - `req_ready_o`=`wb_ready_i`, so a new request is accepted in the same cycle as the response handshake.
  - On handshake: go to BUSY if a multiply was accepted, otherwise IDLE. An unsupported request accepted here pulses `unsupported_o` and the next state is IDLE.
- `flush_i` has priority over everything:
  - In BUSY or RESP, the next state is IDLE; the pending result is discarded and `mult_en_o` drops next cycle.
  - `req_ready_o`=0 in any cycle `flush_i`=1.
- `mult_done_i` is ignored in IDLE and RESP. Stale done pulses after a flush are filtered by the `MUL_LAT` gate.
- `rst_i` mid-operation: immediate return to IDLE; no writeback is issued.

## Timing
- Reset values:
  - State IDLE, so `req_ready_o`=1.
  - `mult_en_o`, `wb_valid_o`, `wb_err_o` and `unsupported_o` are 0.
  - `op_A_o`, `op_B_o`, `wb_data_o` and `wb_rd_o` are 0.
  - `signed_A_o`, `signed_B_o` and `upper_o` are 0.
- Operands and control are registered and stable for the whole of BUSY.
- Accept at edge N: `mult_en_o` is high from N+1.
- Done sampled at edge M: `wb_valid_o` is high from M+1.
- With `multiplier_top` (`MUL_LAT`=4), request-to-writeback latency is 5 cycles; throughput is 1 op per 5 cycles when back-to-back.
- All outputs are registered except `req_ready_o`, which is combinational from state, `wb_ready_i` and `flush_i`.

## Structure
- Package `mdu_pkg` holds:
  - constants `OPC_OP`=7'b0110011 and `F7_MULDIV`=7'b0000001;
  - the funct3 enum (MUL, MULH, MULHSU, MULHU);
  - the FSM state enum.
- The existing combinational `decoder` is instantiated as the sole sub-module for the multiply/signedness/upper decode.

## Test plan
- Async reset asserted mid-cycle -> all outputs at the reset values above immediately; `req_ready_o`=1 after release.
- A=0x80000001, B=0x80010002 with `multiplier_top` attached:
  - MUL -> 0x80010002.
  - MULH -> 0x3FFF7FFE.
  - MULHSU -> 0xBFFF7FFF.
  - MULHU -> 0x40008001.
  - Each returns `wb_rd_o`=`rd_i`, 5 cycles after accept.
- `wb_ready_i` held low 3 cycles in RESP -> `wb_valid_o`/`wb_data_o` held stable and `req_ready_o`=0. Then `wb_ready_i`=1 together with a new MUL request -> accepted in that cycle, `mult_en_o` high the next cycle.
- `flush_i` pulsed in the 2nd BUSY cycle -> no writeback. The next MULHU (A=9, B=7) returns 0x00000000 with no corruption from a stale done.
- Stub multiplier that never asserts done -> after 16 BUSY cycles `wb_valid_o`=1, `wb_err_o`=1, `wb_data_o`=0.
- Request with funct7=0000000, then DIV (funct3=100) -> one `unsupported_o` pulse each, no `wb_valid_o`, state stays IDLE.
